outmem_reader: RTL and testbench

OUTMEM_READER -- requirements
Module: outmem_reader

---
 rtl/outmem_reader.sv | 169 ++++++++++++++++
 tb/tb_outmem_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/outmem_reader.sv
// outmem_reader: drains a layer output memory (channel, row, col order) onto a valid/ready port.
// Optional build macro OUTMEM_READER_CKSUM_EN adds an XOR checksum output over the drained words.
module outmem_reader #(
  parameter int DATA_SIZE = 64,
  parameter int NUM_CH    = 32,
  parameter int OUT_DIM   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 src_valid,
  output logic [2:0][15:0]     rd_index,
  input  logic [DATA_SIZE-1:0] rd_data,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0][15:0]     out_index,
  output logic                 busy,
  output logic                 done
`ifdef OUTMEM_READER_CKSUM_EN
  ,
  output logic [DATA_SIZE-1:0] cksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [15:0] LAST_DIM = 16'(OUT_DIM - 1);
  localparam logic [15:0] LAST_CH  = 16'(NUM_CH - 1);

  state_t      state_r;
  logic [15:0] ch_r, row_r, col_r;
  logic [15:0] ch_nxt_s, row_nxt_s, col_nxt_s;
  logic        last_word_s;
  logic        xfer_s;

  // Next read position: col fastest, wrapping into row, then into channel.
  always_comb begin
    col_nxt_s = col_r + 16'd1;
    row_nxt_s = row_r;
    ch_nxt_s  = ch_r;
    if (col_r == LAST_DIM) begin
      col_nxt_s = 16'd0;
      if (row_r == LAST_DIM) begin
        row_nxt_s = 16'd0;
        ch_nxt_s  = ch_r + 16'd1;
      end else begin
        row_nxt_s = row_r + 16'd1;
      end
    end else begin
      col_nxt_s = col_r + 16'd1;
    end
  end

  assign last_word_s = (ch_r == LAST_CH) && (row_r == LAST_DIM) && (col_r == LAST_DIM);
  assign xfer_s      = out_valid & out_ready;

  // Drain sequencer with registered handshake, address and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      ch_r      <= 16'd0;
      row_r     <= 16'd0;
      col_r     <= 16'd0;
      rd_index  <= '0;
      out_index <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef OUTMEM_READER_CKSUM_EN
      cksum     <= '0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r  <= S_ARM;
            busy     <= 1'b1;
            rd_index <= '0;
`ifdef OUTMEM_READER_CKSUM_EN
            cksum    <= '0;
`endif
          end
        end
        S_ARM: begin
          if (src_valid) begin
            state_r  <= S_RD;
            rd_index <= {ch_r, row_r, col_r};
          end else begin
            rd_index <= '0;
          end
        end
        S_RD: begin
          if (src_valid) begin
            state_r <= S_CAP;
          end else begin
            state_r  <= S_ARM;
            rd_index <= '0;
          end
        end
        S_CAP: begin
          if (src_valid) begin
            state_r   <= S_OUT;
            out_data  <= rd_data;
            out_index <= rd_index;
            out_valid <= 1'b1;
          end else begin
            state_r  <= S_ARM;
            rd_index <= '0;
          end
        end
        S_OUT: begin
          // An accepted word counts even if the source drops in the same cycle.
          if (xfer_s) begin
            out_valid <= 1'b0;
`ifdef OUTMEM_READER_CKSUM_EN
            cksum     <= cksum ^ out_data;
`endif
            if (last_word_s) begin
              state_r <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              ch_r  <= ch_nxt_s;
              row_r <= row_nxt_s;
              col_r <= col_nxt_s;
              if (src_valid) begin
                state_r  <= S_RD;
                rd_index <= {ch_nxt_s, row_nxt_s, col_nxt_s};
              end else begin
                state_r  <= S_ARM;
                rd_index <= '0;
              end
            end
          end else if (!src_valid) begin
            state_r   <= S_ARM;
            out_valid <= 1'b0;
            rd_index  <= '0;
          end
        end
        S_DONE: begin
          state_r  <= S_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          ch_r     <= 16'd0;
          row_r    <= 16'd0;
          col_r    <= 16'd0;
          rd_index <= '0;
        end
        default: begin
          state_r   <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_outmem_reader.sv
// Self-checking bench for outmem_reader: random memory contents and handshake noise,
// checked against an index-order reference model.
module tb_outmem_reader;

  localparam int DW = 64;
  localparam int NW = 800;

  logic             clk, reset, start, src_valid, out_ready;
  logic [2:0][15:0] rd_index, out_index;
  logic [DW-1:0]    rd_data, out_data;
  logic             out_valid, busy, done;
`ifdef OUTMEM_READER_CKSUM_EN
  logic [DW-1:0]    cksum;
`endif

  logic [DW-1:0] mem [NW];
  logic [DW-1:0] exp_ck;
  int checks, errors, exp_k, done_cnt;

  outmem_reader #(.DATA_SIZE(DW), .NUM_CH(32), .OUT_DIM(5)) dut (
    .clk(clk), .reset(reset), .start(start), .src_valid(src_valid),
    .rd_index(rd_index), .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .busy(busy), .done(done)
`ifdef OUTMEM_READER_CKSUM_EN
    , .cksum(cksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lin(input logic [2:0][15:0] idx);
    return int'(idx[2]) * 25 + int'(idx[1]) * 5 + int'(idx[0]);
  endfunction

  function automatic logic [47:0] idx_of(input int k);
    return {16'(k / 25), 16'((k / 5) % 5), 16'(k % 5)};
  endfunction

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (lin(rd_index) < NW) rd_data <= mem[lin(rd_index)];
    else rd_data <= '1;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Record a transfer (if any) with the inputs now in force, then advance one clock.
  task automatic cycle();
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_k < NW) begin
        chk("word_index", 64'(out_index), 64'(idx_of(exp_k)));
        chk("word_data", out_data, mem[exp_k]);
      end else begin
        chk("extra_word", 64'(exp_k), 64'(NW - 1));
      end
      exp_k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int stop_at, input bit events);
    int budget;
    bit fin, stalled, dropped;
    logic [DW-1:0] hd;
    logic [2:0][15:0] hi;
    budget = 0; fin = 1'b0; stalled = 1'b0; dropped = 1'b0;
    while (!fin && budget < 20000) begin
      budget++;
      if (out_valid === 1'b1 && lin(out_index) == stop_at) begin
        fin = 1'b1;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
        src_valid = 1'b1;
        start     = 1'b0;
        if (events) begin
          if ($urandom_range(0, 150) == 0) src_valid = 1'b0;
          if ($urandom_range(0, 60) == 0 && exp_k < 700) start = 1'b1;
        end
        if (events && out_valid === 1'b1 && lin(out_index) == 2 && !stalled) begin
          stalled = 1'b1;
          hd = out_data; hi = out_index;
          out_ready = 1'b0; src_valid = 1'b1; start = 1'b0;
          for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", out_data, hd);
            chk("stall_index", 64'(out_index), 64'(hi));
          end
          out_ready = 1'b1;
        end else if (events && out_valid === 1'b1 && lin(out_index) == 89 && !dropped) begin
          dropped = 1'b1;
          out_ready = 1'b0; src_valid = 1'b0; start = 1'b0;
          cycle();
          chk("drop_valid", 64'(out_valid), 64'd0);
          chk("drop_busy", 64'(busy), 64'd1);
          cycle();
          cycle();
          chk("drop_rd_index", 64'(rd_index), 64'd0);
          src_valid = 1'b1;
        end
        cycle();
        if (done === 1'b1) begin
          fin = 1'b1;
          done_cnt++;
          chk("done_busy", 64'(busy), 64'd0);
          chk("done_count", 64'(exp_k), 64'(NW));
`ifdef OUTMEM_READER_CKSUM_EN
          chk("cksum", cksum, exp_ck);
`endif
        end
      end
    end
    start = 1'b0;
    chk("drain_timeout", 64'(fin), 64'd1);
  endtask

  initial begin
    checks = 0; errors = 0; exp_k = 0; done_cnt = 0;
    reset = 1'b0; start = 1'b0; src_valid = 1'b0; out_ready = 1'b0;
    exp_ck = '0;
    for (int k = 0; k < NW; k++) begin
      mem[k] = {$urandom(), $urandom()};
      exp_ck ^= mem[k];
    end
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_rd_index", 64'(rd_index), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cycle();

    // No start: block stays idle even with a readable source.
    src_valid = 1'b1; out_ready = 1'b1;
    repeat (3) cycle();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(out_valid), 64'd0);

    // Start while the source is not yet valid.
    src_valid = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("arm_busy", 64'(busy), 64'd1);
      chk("arm_valid", 64'(out_valid), 64'd0);
      chk("arm_rd_index", 64'(rd_index), 64'd0);
      cycle();
    end
    src_valid = 1'b1;
    cycle();
    chk("lat_rd", 64'(out_valid), 64'd0);
    cycle();
    chk("lat_cap", 64'(out_valid), 64'd0);
    cycle();
    chk("lat_out", 64'(out_valid), 64'd1);
    chk("lat_index", 64'(out_index), 64'd0);

    // Full drain with stall, source drop, stray starts and random ready.
    drain(-1, 1'b1);
    cycle();
    chk("done_pulse", 64'(done), 64'd0);
    chk("done_once", 64'(done_cnt), 64'd1);

    // Reset in the middle of a drain.
    exp_k = 0;
    out_ready = 1'b1; src_valid = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    drain(256, 1'b0);
    chk("pre_reset_k", 64'(exp_k), 64'd256);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_out_index", 64'(out_index), 64'd0);
    chk("mid_rst_rd_index", 64'(rd_index), 64'd0);
`ifdef OUTMEM_READER_CKSUM_EN
    chk("mid_rst_cksum", cksum, 64'd0);
`endif
    #2 reset = 1'b1;
    repeat (5) cycle();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    // Fresh drain over a linear-index memory image.
    exp_ck = '0;
    for (int k = 0; k < NW; k++) begin
      mem[k] = 64'(k);
      exp_ck ^= mem[k];
    end
    exp_k = 0; done_cnt = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    drain(-1, 1'b0);
    cycle();
    chk("done_once_2", 64'(done_cnt), 64'd1);
    chk("final_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
